neuron_engine: RTL

NEURON_ENGINE -- requirements
Module: neuron_engine

---
 rtl/neuron_engine_pkg.sv | 8 +
 rtl/neuron_act.sv | 18 +
 rtl/neuron_engine.sv | 72 +++++++
 3 files changed

// File: rtl/neuron_engine_pkg.sv
// neuron_engine_pkg: shared FSM states, pass encodings and accumulator width
package neuron_engine_pkg;
  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_ACT, S_DONE} state_t;
  localparam logic [1:0] PASS_H1 = 2'd0;
  localparam logic [1:0] PASS_H2 = 2'd1;
  localparam logic [1:0] PASS_OUT = 2'd2;
  localparam int ACC_W = 32;
endpackage

// File: rtl/neuron_act.sv
// neuron_act: scale, saturate and activate the accumulator
module neuron_act
  import neuron_engine_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [1:0]       pass,
  output logic signed [DW-1:0]    result
);
  localparam int SMAX = 2 ** (DW - 1) - 1;
  logic signed [ACC_W-1:0] s, sat;
  always_comb begin
    s = acc >>> (DW - 1);
    sat = s > SMAX ? SMAX : s < -SMAX - 1 ? -SMAX - 1 : s;
    result = (pass == PASS_H1 || pass == PASS_H2) && sat < 0 ? '0 : sat[DW-1:0];
  end
endmodule

// File: rtl/neuron_engine.sv
// neuron_engine: sequential multiply-accumulate neuron with bias and activation
module neuron_engine
  import neuron_engine_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   neuron_start,
  input  logic        [AW-1:0]   n_last,
  input  logic        [1:0]      pass,
  input  logic signed [2*DW-1:0] bias,
  input  logic signed [DW-1:0]   x_in,
  input  logic signed [DW-1:0]   w_in,
  output logic        [AW-1:0]   addr,
  output logic                   rd_en,
  output logic                   busy,
  output logic                   done,
  output logic signed [DW-1:0]   result
);
  state_t state;
  logic [AW-1:0] n_q;
  logic [1:0] pass_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [2*DW-1:0] prod;
  logic signed [DW-1:0] act;
  assign prod = x_in * w_in;
  neuron_act #(.DW(DW)) u_act (.acc(acc), .pass(pass_q), .result(act));
  // addr doubles as the term index; operands lag it by one cycle, so the
  // first MAC cycle and the DRAIN cycle bracket the accumulation window
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      n_q <= '0;
      pass_q <= '0;
      acc <= '0;
      addr <= '0;
      rd_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if ((state == S_MAC && addr != '0) || state == S_DRAIN) acc <= acc + ACC_W'(prod);
      case (state)
        S_IDLE: if (neuron_start) begin
          state <= S_MAC;
          n_q <= n_last;
          pass_q <= pass;
          acc <= ACC_W'(bias);
          addr <= '0;
          rd_en <= 1'b1;
          busy <= 1'b1;
        end
        S_MAC: if (addr == n_q) begin
          state <= S_DRAIN;
          rd_en <= 1'b0;
        end else addr <= addr + 1'b1;
        S_DRAIN: state <= S_ACT;
        S_ACT: begin
          result <= act;
          done <= 1'b1;
          state <= S_DONE;
        end
        default: begin
          busy <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
endmodule
